// File: rtl/ibus_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// ibus_fetch_queue_if : instruction bus request/response bundle
// Rev 1.0
// ============================================================================
interface ibus_fetch_queue_if;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic        ibus_ack;
   logic [31:0] ibus_rdata;
   logic        ibus_err;

   modport master (
      output ibus_req, ibus_addr,
      input  ibus_ack, ibus_rdata, ibus_err
   );

   modport slave (
      input  ibus_req, ibus_addr,
      output ibus_ack, ibus_rdata, ibus_err
   );
endinterface
`default_nettype wire

// File: rtl/ibus_fetch_queue.sv
`default_nettype none
// ============================================================================
// ibus_fetch_queue : halfword prefetch queue between ibus and the IF stage
// Optional ack-cycle fall-through enabled by macro IBUS_FETCH_BYPASS_EN
// Rev 1.0
// ============================================================================
module ibus_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QUEUE_HW = 6
) (
   input  logic               clk,
   input  logic               rst,
   ibus_fetch_queue_if.master ibus,
   output logic [1:0]         ibusif_vld_size,
   output logic [31:0]        ibusif_data,
   output logic               ibusif_bus_err,
   input  logic               ibusif_pop,
   input  logic [1:0]         ibusif_pop_size,
   input  logic               jmp,
   input  logic [31:0]        jmp_addr
);

   localparam int PW = $clog2(QUEUE_HW);
   localparam int CW = $clog2(QUEUE_HW + 1);

`ifdef IBUS_FETCH_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] k);
      logic [PW:0] s;
      s = {1'b0, p} + {{(PW-1){1'b0}}, k};
      if (s >= (PW+1)'(QUEUE_HW))
         s = s - (PW+1)'(QUEUE_HW);
      return s[PW-1:0];
   endfunction

   logic [15:0]   q_hw  [QUEUE_HW];
   logic          q_err [QUEUE_HW];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          req;
   logic [31:0]   addr;
   logic          skip;
   logic          stop;
   logic          drop;
   logic [31:2]   redir;

   logic [PW-1:0] rd1, wr1;
   logic          accept, bypass_case;
   logic [1:0]    in_n;
   logic [15:0]   in_hw0, in_hw1;
   logic [1:0]    view_n;
   logic [15:0]   view_hw0, view_hw1;
   logic          view_err0, view_err1;
   logic [1:0]    pop_n, shift, qpop, wr_n;
   logic [15:0]   wr_hw0;
   logic [CW-1:0] count_next;
   logic          room;
   logic          pop_bad;
   logic          unused_bits;

   assign ibus.ibus_req  = req;
   assign ibus.ibus_addr = addr;
   assign unused_bits    = ibusif_pop_size[1] ^ jmp_addr[0];

   assign rd1 = ptr_add(rd_ptr, 2'd1);
   assign wr1 = ptr_add(wr_ptr, 2'd1);

   always_comb begin
      accept      = req && ibus.ibus_ack && !drop && !jmp;
      in_n        = skip ? 2'd1 : 2'd2;
      in_hw0      = skip ? ibus.ibus_rdata[31:16] : ibus.ibus_rdata[15:0];
      in_hw1      = ibus.ibus_rdata[31:16];
      bypass_case = BYPASS && accept && (count == '0);

      // The IF-facing view is either the queue head or, on fall-through, the live response
      if (bypass_case) begin
         view_n    = in_n;
         view_hw0  = in_hw0;
         view_hw1  = in_hw1;
         view_err0 = ibus.ibus_err;
         view_err1 = ibus.ibus_err;
      end else begin
         view_n    = (count >= CW'(2)) ? 2'd2 : count[1:0];
         view_hw0  = q_hw[rd_ptr];
         view_hw1  = q_hw[rd1];
         view_err0 = q_err[rd_ptr];
         view_err1 = q_err[rd1];
      end

      if (view_n == 2'd0)
         ibusif_vld_size = 2'd0;
      else if (view_err0 || view_n == 2'd2)
         ibusif_vld_size = 2'd2;
      else
         ibusif_vld_size = 2'd1;
      ibusif_data    = {view_hw1, view_hw0};
      ibusif_bus_err = (view_n != 2'd0) && view_err0;

      pop_n = 2'd0;
      if (ibusif_pop && !jmp && view_n != 2'd0) begin
         if (view_err0)
            pop_n = (view_n == 2'd2 && view_err1) ? 2'd2 : 2'd1;
         else if (ibusif_pop_size[0])
            pop_n = 2'd1;
         else if (view_n == 2'd2)
            pop_n = 2'd2;
      end
      pop_bad = ibusif_pop && !jmp && (pop_n == 2'd0);

      // On fall-through the pop consumes the response first; only the rest is stored
      shift      = bypass_case ? pop_n : 2'd0;
      qpop       = bypass_case ? 2'd0 : pop_n;
      wr_n       = accept ? (in_n - shift) : 2'd0;
      wr_hw0     = (shift != 2'd0) ? in_hw1 : in_hw0;
      count_next = count + CW'(wr_n) - CW'(qpop);
      room       = (count_next <= CW'(QUEUE_HW - 2));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req    <= 1'b0;
         addr   <= {RESET_PC[31:2], 2'b00};
         skip   <= RESET_PC[1];
         stop   <= 1'b0;
         drop   <= 1'b0;
         redir  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (jmp) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         skip   <= jmp_addr[1];
         stop   <= 1'b0;
         // A transfer already on the bus is allowed to complete and its data discarded
         if (req && !ibus.ibus_ack) begin
            drop  <= 1'b1;
            redir <= jmp_addr[31:2];
         end else begin
            drop <= 1'b0;
            req  <= 1'b1;
            addr <= {jmp_addr[31:2], 2'b00};
         end
      end else begin
         rd_ptr <= ptr_add(rd_ptr, qpop);
         wr_ptr <= ptr_add(wr_ptr, wr_n);
         count  <= count_next;
         if (req && ibus.ibus_ack) begin
            if (drop) begin
               drop <= 1'b0;
               req  <= 1'b1;
               addr <= {redir, 2'b00};
            end else begin
               addr <= addr + 32'd4;
               skip <= 1'b0;
               if (ibus.ibus_err) begin
                  stop <= 1'b1;
                  req  <= 1'b0;
               end else begin
                  req <= room;
               end
            end
         end else if (!req) begin
            req <= !stop && room;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_n != 2'd0) begin
         q_hw[wr_ptr]  <= wr_hw0;
         q_err[wr_ptr] <= ibus.ibus_err;
      end
      if (wr_n == 2'd2) begin
         q_hw[wr1]  <= in_hw1;
         q_err[wr1] <= ibus.ibus_err;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst)
         assert (!pop_bad);
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ibus_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_ibus_fetch_queue : directed scoreboard bench for ibus_fetch_queue
// Rev 1.0
// ============================================================================
module tb_ibus_fetch_queue;

   logic        clk;
   logic        rst;
   logic [1:0]  vld_size;
   logic [31:0] data;
   logic        bus_err;
   logic        pop;
   logic [1:0]  pop_size;
   logic        jmp;
   logic [31:0] jmp_addr;

   int checks   = 0;
   int failures = 0;

   logic [16:0] sb[$];

   ibus_fetch_queue_if bus ();

   ibus_fetch_queue #(
      .RESET_PC (32'h0000_0000),
      .QUEUE_HW (6)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .ibus            (bus),
      .ibusif_vld_size (vld_size),
      .ibusif_data     (data),
      .ibusif_bus_err  (bus_err),
      .ibusif_pop      (pop),
      .ibusif_pop_size (pop_size),
      .jmp             (jmp),
      .jmp_addr        (jmp_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within bound");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag);
      logic [1:0] ev;
      if (sb.size() == 0)      ev = 2'd0;
      else if (sb[0][16])      ev = 2'd2;
      else if (sb.size() == 1) ev = 2'd1;
      else                     ev = 2'd2;
      chk({tag, "_vld"}, {30'd0, vld_size}, {30'd0, ev});
      chk({tag, "_err"}, {31'd0, bus_err}, {31'd0, (sb.size() != 0) && sb[0][16]});
      if (sb.size() >= 1 && !sb[0][16])
         chk({tag, "_lo"}, {16'd0, data[15:0]}, {16'd0, sb[0][15:0]});
      if (sb.size() >= 2 && !sb[0][16])
         chk({tag, "_hi"}, {16'd0, data[31:16]}, {16'd0, sb[1][15:0]});
   endtask

   // Respond to the pending request; keep=1 means the response is expected to enter the queue
   task automatic ack_now(input logic [31:0] rd, input logic er, input logic skp, input logic keep);
      chk("ack_req_high", {31'd0, bus.ibus_req}, 32'd1);
      if (keep) begin
         if (!skp) sb.push_back({er, rd[15:0]});
         sb.push_back({er, rd[31:16]});
      end
      bus.ibus_ack   = 1'b1;
      bus.ibus_rdata = rd;
      bus.ibus_err   = er;
      tick();
      bus.ibus_ack   = 1'b0;
      bus.ibus_err   = 1'b0;
   endtask

   task automatic do_pop(input logic half);
      pop      = 1'b1;
      pop_size = {1'b0, half};
      tick();
      pop = 1'b0;
      if (sb[0][16]) begin
         void'(sb.pop_front());
         if (sb.size() != 0 && sb[0][16]) void'(sb.pop_front());
      end else if (half) begin
         void'(sb.pop_front());
      end else begin
         void'(sb.pop_front());
         void'(sb.pop_front());
      end
   endtask

   task automatic do_jmp(input logic [31:0] target);
      jmp      = 1'b1;
      jmp_addr = target;
      tick();
      jmp = 1'b0;
      sb.delete();
   endtask

   initial begin
      rst            = 1'b1;
      pop            = 1'b0;
      pop_size       = 2'd0;
      jmp            = 1'b0;
      jmp_addr       = 32'd0;
      bus.ibus_ack   = 1'b0;
      bus.ibus_rdata = 32'd0;
      bus.ibus_err   = 1'b0;
      tick(); tick(); tick();

      // reset state
      chk("rst_req",  {31'd0, bus.ibus_req}, 32'd0);
      chk("rst_addr", bus.ibus_addr, 32'd0);
      chk_head("rst");

      rst = 1'b0;
      tick();
      chk("first_req",  {31'd0, bus.ibus_req}, 32'd1);
      chk("first_addr", bus.ibus_addr, 32'd0);

      // sequential fill with rdata = addr until the queue stops requesting
      for (int i = 0; i < 3; i++) begin
         chk("fill_addr", bus.ibus_addr, 32'(4 * i));
         ack_now(32'(4 * i), 1'b0, 1'b0, 1'b1);
         chk_head("fill");
      end
      chk("fill_data0", data, 32'h0000_0000);
      chk("full_req_low", {31'd0, bus.ibus_req}, 32'd0);
      tick(); tick();
      chk("full_req_stall", {31'd0, bus.ibus_req}, 32'd0);
      do_pop(1'b0);
      chk_head("after_pop32");
      chk("refill_req",  {31'd0, bus.ibus_req}, 32'd1);
      chk("refill_addr", bus.ibus_addr, 32'd12);

      // redirect while the request to 12 is outstanding; slave answers later
      do_jmp(32'h0000_0200);
      chk_head("jmp_flush");
      chk("pend_addr0", bus.ibus_addr, 32'd12);
      tick(); tick();
      chk("pend_addr1", bus.ibus_addr, 32'd12);
      chk("pend_req",   {31'd0, bus.ibus_req}, 32'd1);
      ack_now(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      chk_head("dropped");
      chk("redir_req",  {31'd0, bus.ibus_req}, 32'd1);
      chk("redir_addr", bus.ibus_addr, 32'h0000_0200);

      // mixed 16/32/16 pops over 0x2222_1111, 0x4444_3333
      ack_now(32'h2222_1111, 1'b0, 1'b0, 1'b1);
      chk("stream_addr", bus.ibus_addr, 32'h0000_0204);
      ack_now(32'h4444_3333, 1'b0, 1'b0, 1'b1);
      chk_head("mix0");
      chk("mix_head0", data, 32'h2222_1111);
      do_pop(1'b1);
      chk_head("mix1");
      chk("mix_head1", data, 32'h3333_2222);
      do_pop(1'b0);
      chk_head("mix2");
      chk("mix_vld1", {30'd0, vld_size}, 32'd1);
      chk("mix_head2", {16'd0, data[15:0]}, 32'h0000_4444);

      // bus error on the fetch of 0x208 stops further requests
      chk("err_addr", bus.ibus_addr, 32'h0000_0208);
      ack_now(32'hEEEE_EEEE, 1'b1, 1'b0, 1'b1);
      chk_head("err0");
      chk("err_stop0", {31'd0, bus.ibus_req}, 32'd0);
      do_pop(1'b1);
      chk_head("err_head");
      chk("err_flag", {31'd0, bus_err}, 32'd1);
      do_pop(1'b1);
      chk_head("err_gone");
      tick(); tick();
      chk("err_stop1", {31'd0, bus.ibus_req}, 32'd0);

      // redirect to a halfword address with nothing outstanding
      do_jmp(32'h0000_0102);
      chk("j102_req",  {31'd0, bus.ibus_req}, 32'd1);
      chk("j102_addr", bus.ibus_addr, 32'h0000_0100);
      ack_now(32'hBBBB_AAAA, 1'b0, 1'b1, 1'b1);
      chk_head("skip");
      chk("skip_vld1", {30'd0, vld_size}, 32'd1);
      chk("skip_data", {16'd0, data[15:0]}, 32'h0000_BBBB);
      chk("skip_next", bus.ibus_addr, 32'h0000_0104);

      // jmp in the same cycle as an ack
      jmp            = 1'b1;
      jmp_addr       = 32'h0000_0300;
      bus.ibus_ack   = 1'b1;
      bus.ibus_rdata = 32'h5555_5555;
      tick();
      jmp          = 1'b0;
      bus.ibus_ack = 1'b0;
      sb.delete();
      chk_head("jack");
      chk("jack_req",  {31'd0, bus.ibus_req}, 32'd1);
      chk("jack_addr", bus.ibus_addr, 32'h0000_0300);
      ack_now(32'h7777_6666, 1'b0, 1'b0, 1'b1);
      chk_head("jack_data");

      // back-to-back jmps while outstanding: last target wins
      do_jmp(32'h0000_0400);
      do_jmp(32'h0000_0502);
      chk("b2b_hold", bus.ibus_addr, 32'h0000_0304);
      chk_head("b2b_flush");
      ack_now(32'h9999_9999, 1'b0, 1'b0, 1'b0);
      chk("b2b_addr", bus.ibus_addr, 32'h0000_0500);
      ack_now(32'hCCCC_DDDD, 1'b0, 1'b1, 1'b1);
      chk_head("b2b_data");

      // ack into an empty queue: fall-through only when bypass is built in
      do_pop(1'b1);
      chk_head("empty");
      chk("byp_req", {31'd0, bus.ibus_req}, 32'd1);
      bus.ibus_ack   = 1'b1;
      bus.ibus_rdata = 32'h1234_5678;
      #1;
`ifdef IBUS_FETCH_BYPASS_EN
      chk("byp_vld",  {30'd0, vld_size}, 32'd2);
      chk("byp_data", data, 32'h1234_5678);
`else
      chk("nobyp_vld", {30'd0, vld_size}, 32'd0);
`endif
      sb.push_back({1'b0, 16'h5678});
      sb.push_back({1'b0, 16'h1234});
      @(posedge clk);
      #1;
      bus.ibus_ack = 1'b0;
      chk_head("lat");
      chk("lat_data", data, 32'h1234_5678);

      // address wraps modulo 2^32
      do_jmp(32'hFFFF_FFFC);
      ack_now(32'h0, 1'b0, 1'b0, 1'b0);
      chk("wrap_hi", bus.ibus_addr, 32'hFFFF_FFFC);
      ack_now(32'hABCD_0123, 1'b0, 1'b0, 1'b1);
      chk("wrap_lo", bus.ibus_addr, 32'h0000_0000);
      chk_head("wrap");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
